match_engine: RTL and testbench
===============================

Name: match_engine

Overview:
- Parametrised successor of the pair-only game flow in state_machine.
- Plays a memory round: accepts card clicks, reveals cards, and compares groups of GROUP_SIZE cards.
- Writes card states back through the regfile write port, rotates turns among NUM_PLAYERS, and keeps per-player scores and a move counter.
- Sits between cardsCtl (click events) and regfileCtl (write_data_2); runs in the 65 MHz domain.

Parameters:
- ADDR_W, 5, card address width; max cards 2**ADDR_W.
- COLOR_W, 4, card colour width.
- GROUP_SIZE, 2, cards per match group; legal 2..4.
- NUM_PLAYERS, 2, players taking turns; legal 1..4.
- SCORE_W, 6, per-player score width; saturating.
- MOVES_W, 10, move counter width; saturating.
- HOLD_CYCLES, 65000000, mismatch display time in clk cycles; >=1.

Ports:
- clk  in  1  65 MHz pixel/system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin a new game (clears scores, moves, turn)
- num_of_cards  in  ADDR_W+1  cards in play, sampled on start
- card_pressed  in  1  pulse; a card was clicked
- card_addr  in  ADDR_W  address of clicked card
- card_color  in  COLOR_W  colour of clicked card (regfile read data)
- card_state  in  2  state of clicked card; 0=HIDDEN, 1=SHOWN, 2=MATCHED
- wait_for_click  out  1  high while clicks are accepted
- write_en  out  1  one-cycle regfile write strobe
- write_addr  out  ADDR_W  regfile write address
- write_state  out  2  state value to write
- cur_player  out  2  index of player on turn
- scores  out  NUM_PLAYERS*SCORE_W  player p at bits [p*SCORE_W +: SCORE_W]
- moves  out  MOVES_W  completed groups
- game_over  out  1  level; high once all cards are matched
- winner_mask  out  NUM_PLAYERS  bit p set if player p holds the max score; valid while game_over

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0. Group buffer and counters cleared.
- States: IDLE, WAIT_CLICK, SHOW, CHECK, HOLD, WRITE_BACK, NEXT_TURN, GAME_OVER.
- IDLE: on start, latch num_of_cards, clear scores/moves/cur_player/matched_cnt, go to WAIT_CLICK.
- WAIT_CLICK: wait_for_click=1.
  - Accept a click only if card_pressed=1 and card_state=HIDDEN. Ignore SHOWN or MATCHED cards, and ignore any click in any other state.
  - On accept: store {card_addr, card_color} in buffer slot sel_cnt, increment sel_cnt, go to SHOW.
- SHOW: write_en=1, write_state=SHOWN, write_addr=stored addr; this is exactly 1 cycle after the click.
  - Next state: CHECK if sel_cnt==GROUP_SIZE, else WAIT_CLICK.
- CHECK (1 cycle): match = every buffered colour equals slot 0; moves+=1, saturating.
  - Match: go to WRITE_BACK with target MATCHED.
  - Mismatch: load hold counter, go to HOLD.
- HOLD: count HOLD_CYCLES cycles, then go to WRITE_BACK with target HIDDEN.
- WRITE_BACK: GROUP_SIZE consecutive cycles, write_en=1, slots 0..GROUP_SIZE-1 in order.
  - Then on match: scores[cur_player]+=1 (saturating) and matched_cnt+=GROUP_SIZE.
  - Go to NEXT_TURN.
- NEXT_TURN (1 cycle): clear sel_cnt.
  - On mismatch, cur_player = (cur_player+1) mod NUM_PLAYERS; on match the same player keeps the turn.
  - If num_of_cards - matched_cnt < GROUP_SIZE, go to GAME_OVER; else WAIT_CLICK.
- GAME_OVER: game_over=1. winner_mask is computed combinationally and registered on entry; ties set multiple bits. Leave only on start.
- start in any non-IDLE state restarts the game the next cycle. Any in-flight write_en is dropped and no pending writes are issued.
- A card_pressed coincident with start is ignored.
- num_of_cards=0 or <GROUP_SIZE: start goes straight through to GAME_OVER, with winner_mask all ones.
- Saturation: scores stop at 2**SCORE_W-1 and moves at 2**MOVES_W-1; no wrap.
- Reset mid-HOLD or mid-WRITE_BACK aborts immediately with no further writes. The regfile is re-initialised by compute_colors on the next game.

Decomposition:
- Shared package/header `_game_params.vh`: card state encodings (HIDDEN/SHOWN/MATCHED), CARD_STATE_SIZE, CARD_ADDRESS_SIZE, CARD_COLOR_SIZE.
- match_engine keeps the FSM plus a sub-module score_board. score_board holds per-player saturating scores, the increment strobe, a clear, and the max-score winner_mask reduction.
- Group buffer and hold counter stay inline.

Test Plan:
- Bench uses HOLD_CYCLES=4. Common setup: GROUP_SIZE=2, NUM_PLAYERS=2 unless stated; rst low then high; start with num_of_cards=4.
- Match: click addr 1 then 3, both colour 5, HIDDEN -> SHOWN writes 1 cycle after each click. Then MATCHED writes to 1 and 3 on consecutive cycles; scores[0]=1, moves=1, cur_player stays 0.
- Mismatch: click addr 0 colour 2, then addr 2 colour 7 -> 4 cycles with no writes, then HIDDEN writes to 0 and 2; cur_player=1, scores unchanged, moves=1.
- Invalid clicks: click with card_state=SHOWN, or a click pulse during HOLD -> no write_en, buffer unchanged, sel_cnt unchanged.
- Game end: match both pairs of 4 cards with player 0 -> game_over=1 and winner_mask=2'b01. With a 1-1 tie, winner_mask=2'b11.
- Generalised config: GROUP_SIZE=3, NUM_PLAYERS=3, num_of_cards=6.
  - Three equal colours -> 3 MATCHED writes, score +1.
  - Mismatch -> turn goes 0->1->2->0 on successive misses.
- Start/reset mid-operation: start asserted during WRITE_BACK -> writes stop, scores=0, wait_for_click=1 the cycle after. rst low mid-HOLD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/match_engine_pkg.sv
// Shared card encodings and FSM state type for the memory-game match engine.
package match_engine_pkg;

  localparam int CARD_STATE_SIZE   = 2;
  localparam int CARD_ADDRESS_SIZE = 5;
  localparam int CARD_COLOR_SIZE   = 4;

  typedef enum logic [CARD_STATE_SIZE-1:0] {
    HIDDEN  = 2'd0,
    SHOWN   = 2'd1,
    MATCHED = 2'd2
  } card_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CLICK,
    S_SHOW,
    S_CHECK,
    S_HOLD,
    S_WRITE_BACK,
    S_NEXT_TURN,
    S_GAME_OVER
  } me_state_e;

endpackage

// File: rtl/match_engine_score_board.sv
// Per-player saturating score registers and the max-score winner mask.
module score_board #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  inc,
  input  logic [1:0]                            player,
  output logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   scores,
  output logic [NUM_PLAYERS-1:0]                winner_mask
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scores <= '0;
    end else if (clear) begin
      scores <= '0;
    end else if (inc) begin
      for (int p = 0; p < NUM_PLAYERS; p++)
        if (player == 2'(p) && scores[p] != '1)
          scores[p] <= scores[p] + 1'b1;
    end
  end

  // Ties flag every player sharing the top score.
  logic [SCORE_W-1:0] best;
  always_comb begin
    best        = '0;
    winner_mask = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (scores[p] > best) best = scores[p];
    for (int p = 0; p < NUM_PLAYERS; p++)
      winner_mask[p] = (scores[p] == best);
  end

endmodule

// File: rtl/match_engine.sv
// Memory-game round controller: collects click groups, compares colours,
// writes card states back to the regfile and tracks turns, scores and moves.
module match_engine
  import match_engine_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int COLOR_W     = 4,
  parameter int GROUP_SIZE  = 2,
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 6,
  parameter int MOVES_W     = 10,
  parameter int HOLD_CYCLES = 65000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_W:0]                 num_of_cards,
  input  logic                            card_pressed,
  input  logic [ADDR_W-1:0]               card_addr,
  input  logic [COLOR_W-1:0]              card_color,
  input  logic [1:0]                      card_state,
  output logic                            wait_for_click,
  output logic                            write_en,
  output logic [ADDR_W-1:0]               write_addr,
  output logic [1:0]                      write_state,
  output logic [1:0]                      cur_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0]  scores,
  output logic [MOVES_W-1:0]              moves,
  output logic                            game_over,
  output logic [NUM_PLAYERS-1:0]          winner_mask
);

  localparam int SEL_W  = $clog2(GROUP_SIZE + 1);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  me_state_e state, nxt;

  logic [CNT_W-1:0]                     n_cards, matched_cnt, remaining;
  logic [GROUP_SIZE-1:0][ADDR_W-1:0]    buf_addr;
  logic [GROUP_SIZE-1:0][COLOR_W-1:0]   buf_color;
  logic [SEL_W-1:0]                     sel_cnt, wb_idx;
  logic [HOLD_W-1:0]                    hold_cnt;
  logic [ADDR_W-1:0]                    show_addr, wb_addr;
  logic [1:0]                           player_q;
  logic [MOVES_W-1:0]                   moves_q;
  logic [NUM_PLAYERS-1:0]               win_q, sb_win;
  logic                                 is_match, group_match, click_ok;
  logic                                 wb_last, end_game, start_short, sb_inc;

  assign click_ok    = (state == S_WAIT_CLICK) && card_pressed && !start &&
                       (card_state == HIDDEN);
  assign wb_last     = (wb_idx == SEL_W'(GROUP_SIZE - 1));
  assign remaining   = n_cards - matched_cnt;
  assign end_game    = (remaining < CNT_W'(GROUP_SIZE));
  assign start_short = (num_of_cards < CNT_W'(GROUP_SIZE));
  assign sb_inc      = (state == S_WRITE_BACK) && wb_last && is_match && !start;

  always_comb begin
    group_match = 1'b1;
    for (int i = 1; i < GROUP_SIZE; i++)
      if (buf_color[i] != buf_color[0]) group_match = 1'b0;
  end

  always_comb begin
    wb_addr = '0;
    for (int i = 0; i < GROUP_SIZE; i++)
      if (wb_idx == SEL_W'(i)) wb_addr = buf_addr[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt            = state;
    wait_for_click = 1'b0;
    write_en       = 1'b0;
    write_addr     = '0;
    write_state    = HIDDEN;
    game_over      = 1'b0;
    case (state)
      S_IDLE: ;
      S_WAIT_CLICK: begin
        wait_for_click = 1'b1;
        if (click_ok) nxt = S_SHOW;
      end
      S_SHOW: begin
        write_en    = 1'b1;
        write_addr  = show_addr;
        write_state = SHOWN;
        nxt = (sel_cnt == SEL_W'(GROUP_SIZE)) ? S_CHECK : S_WAIT_CLICK;
      end
      S_CHECK: nxt = group_match ? S_WRITE_BACK : S_HOLD;
      S_HOLD:  if (hold_cnt == '0) nxt = S_WRITE_BACK;
      S_WRITE_BACK: begin
        write_en    = 1'b1;
        write_addr  = wb_addr;
        write_state = is_match ? MATCHED : HIDDEN;
        if (wb_last) nxt = S_NEXT_TURN;
      end
      S_NEXT_TURN: nxt = end_game ? S_GAME_OVER : S_WAIT_CLICK;
      S_GAME_OVER: game_over = 1'b1;
      default:     nxt = S_IDLE;
    endcase
    // A restart wins over everything, including a write already on the bus.
    if (start) begin
      nxt      = start_short ? S_GAME_OVER : S_WAIT_CLICK;
      write_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_cards     <= '0;
      matched_cnt <= '0;
      buf_addr    <= '0;
      buf_color   <= '0;
      sel_cnt     <= '0;
      wb_idx      <= '0;
      hold_cnt    <= '0;
      show_addr   <= '0;
      player_q    <= '0;
      moves_q     <= '0;
      win_q       <= '0;
      is_match    <= 1'b0;
    end else if (start) begin
      n_cards     <= num_of_cards;
      matched_cnt <= '0;
      sel_cnt     <= '0;
      wb_idx      <= '0;
      hold_cnt    <= '0;
      player_q    <= '0;
      moves_q     <= '0;
      is_match    <= 1'b0;
      win_q       <= start_short ? '1 : '0;
    end else begin
      case (state)
        S_WAIT_CLICK: if (click_ok) begin
          for (int i = 0; i < GROUP_SIZE; i++)
            if (sel_cnt == SEL_W'(i)) begin
              buf_addr[i]  <= card_addr;
              buf_color[i] <= card_color;
            end
          show_addr <= card_addr;
          sel_cnt   <= sel_cnt + 1'b1;
        end
        S_CHECK: begin
          is_match <= group_match;
          hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
          wb_idx   <= '0;
          if (moves_q != '1) moves_q <= moves_q + 1'b1;
        end
        S_HOLD: if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        S_WRITE_BACK: begin
          if (wb_last) begin
            wb_idx <= '0;
            if (is_match) matched_cnt <= matched_cnt + CNT_W'(GROUP_SIZE);
          end else begin
            wb_idx <= wb_idx + 1'b1;
          end
        end
        S_NEXT_TURN: begin
          sel_cnt <= '0;
          if (!is_match)
            player_q <= (player_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : player_q + 2'd1;
          if (end_game) win_q <= sb_win;
        end
        default: ;
      endcase
    end
  end

  score_board #(.NUM_PLAYERS(NUM_PLAYERS), .SCORE_W(SCORE_W)) u_score_board (
    .clk         (clk),
    .rst         (rst),
    .clear       (start),
    .inc         (sb_inc),
    .player      (player_q),
    .scores      (scores),
    .winner_mask (sb_win)
  );

  assign cur_player  = player_q;
  assign moves       = moves_q;
  assign winner_mask = win_q;

endmodule

// File: tb/tb_match_engine.sv
// Scoreboard bench for match_engine: two configurations (2x2 and 3x3) checked
// against a game-level reference model.
module tb_match_engine;
  localparam int HOLD = 4;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 0, card_pressed = 0;
  logic [5:0] num_of_cards = '0;
  logic [4:0] card_addr = '0;
  logic [3:0] card_color = '0;
  logic [1:0] card_state = '0;
  int         sel = 0;

  logic a_wfc, a_we, a_go; logic [4:0] a_wa; logic [1:0] a_ws, a_pl, a_wm;
  logic [11:0] a_sc; logic [9:0] a_mv;
  logic b_wfc, b_we, b_go; logic [4:0] b_wa; logic [1:0] b_ws, b_pl; logic [2:0] b_wm;
  logic [17:0] b_sc; logic [9:0] b_mv;

  match_engine #(.ADDR_W(5), .COLOR_W(4), .GROUP_SIZE(2), .NUM_PLAYERS(2),
                 .SCORE_W(6), .MOVES_W(10), .HOLD_CYCLES(HOLD)) u_a (
    .clk(clk), .rst(rst), .start(start && sel == 0), .num_of_cards(num_of_cards),
    .card_pressed(card_pressed && sel == 0), .card_addr(card_addr),
    .card_color(card_color), .card_state(card_state), .wait_for_click(a_wfc),
    .write_en(a_we), .write_addr(a_wa), .write_state(a_ws), .cur_player(a_pl),
    .scores(a_sc), .moves(a_mv), .game_over(a_go), .winner_mask(a_wm));

  match_engine #(.ADDR_W(5), .COLOR_W(4), .GROUP_SIZE(3), .NUM_PLAYERS(3),
                 .SCORE_W(6), .MOVES_W(10), .HOLD_CYCLES(HOLD)) u_b (
    .clk(clk), .rst(rst), .start(start && sel == 1), .num_of_cards(num_of_cards),
    .card_pressed(card_pressed && sel == 1), .card_addr(card_addr),
    .card_color(card_color), .card_state(card_state), .wait_for_click(b_wfc),
    .write_en(b_we), .write_addr(b_wa), .write_state(b_ws), .cur_player(b_pl),
    .scores(b_sc), .moves(b_mv), .game_over(b_go), .winner_mask(b_wm));

  logic o_wfc, o_we, o_go; logic [4:0] o_wa; logic [1:0] o_ws, o_pl;
  logic [17:0] o_sc; logic [9:0] o_mv; logic [2:0] o_wm;
  always_comb begin
    if (sel == 0) begin
      o_wfc = a_wfc; o_we = a_we; o_go = a_go; o_wa = a_wa; o_ws = a_ws; o_pl = a_pl;
      o_sc = {6'b0, a_sc}; o_mv = a_mv; o_wm = {1'b0, a_wm};
    end else begin
      o_wfc = b_wfc; o_we = b_we; o_go = b_go; o_wa = b_wa; o_ws = b_ws; o_pl = b_pl;
      o_sc = b_sc; o_mv = b_mv; o_wm = b_wm;
    end
  end

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int st; int cyc; } wr_t;
  wr_t exp_q[$];

  // Reference game state (card states: 0 hidden, 1 shown, 2 matched).
  int G, NP, ncards, mplayer, mmoves, mmatched, mwin;
  int mcolor[32], mstate[32], mscore[4];
  bit mover;
  int sel_list[$];

  task automatic chk(string name, longint got, longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every write must be the next expected one, at the expected cycle.
  always @(negedge clk) begin
    if (o_we) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write addr=%0d st=%0d cyc=%0d", o_wa, o_ws, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checks++;
        if (o_wa != e.addr || o_ws != e.st || cyc != e.cyc) begin
          failures++;
          $display("FAIL write got addr=%0d st=%0d cyc=%0d want addr=%0d st=%0d cyc=%0d",
                   o_wa, o_ws, cyc, e.addr, e.st, e.cyc);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      wr_t e;
      e = exp_q.pop_front();
      checks++; failures++;
      $display("FAIL missing_write addr=%0d st=%0d due=%0d now=%0d", e.addr, e.st, e.cyc, cyc);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic model_finish();
    int best = 0;
    mover = 1; mwin = 0;
    for (int p = 0; p < NP; p++) if (mscore[p] > best) best = mscore[p];
    for (int p = 0; p < NP; p++) if (mscore[p] == best) mwin |= (1 << p);
  endtask

  task automatic model_click(int a, int st, int c);
    bit eq;
    if (st != 0) return;
    exp_q.push_back('{a, 1, c + 1});
    mstate[a] = 1;
    sel_list.push_back(a);
    if (sel_list.size() == G) begin
      eq = 1;
      foreach (sel_list[i]) if (mcolor[sel_list[i]] != mcolor[sel_list[0]]) eq = 0;
      if (mmoves < 1023) mmoves++;
      foreach (sel_list[i]) begin
        exp_q.push_back('{sel_list[i], eq ? 2 : 0, c + 3 + (eq ? 0 : HOLD) + i});
        mstate[sel_list[i]] = eq ? 2 : 0;
      end
      if (eq) begin
        if (mscore[mplayer] < 63) mscore[mplayer]++;
        mmatched += G;
      end else mplayer = (mplayer + 1) % NP;
      sel_list.delete();
      if (ncards - mmatched < G) model_finish();
    end
  endtask

  task automatic check_outs(string tag);
    logic [17:0] es = '0;
    for (int p = 0; p < NP; p++) es |= 18'(mscore[p]) << (6 * p);
    chk({tag, "_player"}, o_pl, mplayer);
    chk({tag, "_scores"}, o_sc, es);
    chk({tag, "_moves"}, o_mv, mmoves);
    chk({tag, "_game_over"}, o_go, mover);
    if (mover) chk({tag, "_winner"}, o_wm, mwin);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic settle(string tag);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (o_wfc || o_go) ok = 1;
      else tick();
    end
    if (!ok) chk({tag, "_settle_timeout"}, 0, 1);
  endtask

  task automatic do_start(int n);
    wr_t k[$];
    foreach (exp_q[i]) if (exp_q[i].cyc < cyc) k.push_back(exp_q[i]);
    exp_q = k;
    start = 1; num_of_cards = 6'(n);
    ncards = n; mplayer = 0; mmoves = 0; mmatched = 0; mover = 0; mwin = 0;
    sel_list.delete();
    for (int p = 0; p < 4; p++) mscore[p] = 0;
    for (int i = 0; i < 32; i++) mstate[i] = 0;
    if (n < G) model_finish();
    tick();
    start = 0;
    chk("start_wfc", o_wfc, (n >= G));
  endtask

  task automatic drive_click(int a, int st);
    card_pressed = 1; card_addr = 5'(a); card_color = 4'(mcolor[a]); card_state = 2'(st);
    tick();
    card_pressed = 0;
  endtask

  task automatic do_click(int a, int st);
    settle("click");
    model_click(a, st, cyc);
    drive_click(a, st);
  endtask

  task automatic click(int a); do_click(a, mstate[a]); endtask

  task automatic set_colors(int n, int c0, int c1, int c2, int c3, int c4, int c5);
    int v[6];
    v = '{c0, c1, c2, c3, c4, c5};
    for (int i = 0; i < n; i++) mcolor[i] = v[i];
  endtask

  task automatic rand_game(int n);
    int t, a;
    int hid[$];
    for (int i = 0; i < n; i++) mcolor[i] = (i / G < n / G) ? i / G : 15;
    for (int i = n - 1; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      t = mcolor[i]; mcolor[i] = mcolor[j]; mcolor[j] = t;
    end
    do_start(n);
    for (int k = 0; k < 400 && !mover; k++) begin
      hid.delete();
      for (int i = 0; i < n; i++) if (mstate[i] == 0) hid.push_back(i);
      if ($urandom_range(4, 0) == 0 || hid.size() == 0) a = $urandom_range(n - 1, 0);
      else a = hid[$urandom_range(hid.size() - 1, 0)];
      click(a);
    end
    settle("rand");
    check_outs("rand_end");
  endtask

  initial begin
    G = 2; NP = 2; sel = 0;
    #1 rst = 0;
    tick(); tick();
    chk("rst_we", o_we, 0); chk("rst_wfc", o_wfc, 0); chk("rst_player", o_pl, 0);
    chk("rst_scores", o_sc, 0); chk("rst_moves", o_mv, 0);
    chk("rst_go", o_go, 0); chk("rst_winner", o_wm, 0);
    rst = 1; tick();

    // Match, mismatch with a click during HOLD, then ignored clicks.
    set_colors(4, 2, 5, 7, 5, 0, 0);
    do_start(4); check_outs("start");
    click(1); click(3); settle("m"); check_outs("match");
    click(0); click(2);
    tick(); tick(); drive_click(1, 0);
    settle("mm"); check_outs("mismatch");
    do_click(0, 1); chk("shown_click_wfc", o_wfc, 1);
    do_click(1, 2); chk("matched_click_wfc", o_wfc, 1);
    settle("inv"); check_outs("invalid");

    // Single player sweeps the board.
    set_colors(4, 4, 4, 9, 9, 0, 0);
    do_start(4);
    click(0); click(1); click(2); click(3); settle("w"); check_outs("win01");

    // Odd card count ends after two pairs with a 1-1 tie.
    set_colors(5, 1, 1, 2, 2, 3, 0);
    do_start(5);
    click(0); click(1); click(2); click(4); click(2); click(3);
    settle("tie"); check_outs("tie");

    // Start coincident with a click, then start during WRITE_BACK.
    set_colors(4, 1, 1, 3, 3, 0, 0);
    do_start(4);
    start = 1; num_of_cards = 6'd4; card_pressed = 1; card_addr = 5'd2;
    card_color = 4'd3; card_state = 2'd0;
    tick(); start = 0; card_pressed = 0;
    tick(); check_outs("start_click");
    click(0); click(1); tick(); tick();
    do_start(4); check_outs("restart_wb");

    // Too few cards: straight to GAME_OVER with everyone winning.
    do_start(1); tick(); check_outs("short1");
    do_start(0); tick(); check_outs("short0");

    // Reset during HOLD.
    set_colors(4, 1, 2, 3, 4, 0, 0);
    do_start(4); click(0); click(1); tick(); tick();
    rst = 0; #1;
    chk("hold_rst_we", o_we, 0); chk("hold_rst_wfc", o_wfc, 0);
    chk("hold_rst_moves", o_mv, 0); chk("hold_rst_go", o_go, 0);
    exp_q.delete();
    tick(); rst = 1; tick();

    for (int r = 0; r < 4; r++) rand_game((r % 2 == 0) ? 4 : 7);

    // Three-player, three-card groups.
    sel = 1; G = 3; NP = 3;
    set_colors(6, 5, 5, 5, 8, 9, 10);
    do_start(6);
    click(3); click(4); click(5); settle("g1"); check_outs("miss_p1");
    click(3); click(4); click(5); settle("g2"); check_outs("miss_p2");
    click(3); click(4); click(5); settle("g3"); check_outs("miss_p0");
    click(0); click(1); click(2); settle("g4"); check_outs("match3");
    for (int r = 0; r < 3; r++) rand_game(6 + 3 * (r % 2));

    tick(); tick();
    chk("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
